// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester drives start/a/b; the subtractor returns busy/done/diff/bout.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, LSB first over WIDTH cycles, with borrow-out.
// Operands are captured on an accepted start; diff/bout hold until the next result lands.
module serial_sub #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 3
) (
    input logic         clk,
    input logic         rst_n,
    serial_sub_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;

    // One full-subtractor bit per cycle on the current LSBs.
    assign d_bit     = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign res_shift = {d_bit, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                res_d = res_shift;
                br_d  = br_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_sub.sv
// Randomised and directed bench for serial_sub (WIDTH=4 main instance, WIDTH=8 side instance)
// checked every cycle against a cycle-count/arithmetic reference model.
module tb_serial_sub;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    serial_sub_if #(.WIDTH(W)) bus ();
    serial_sub_if #(.WIDTH(8)) bus8 ();

    serial_sub #(.WIDTH(W), .CW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    serial_sub #(.WIDTH(8), .CW(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    // Reference: remaining busy cycles after acceptance, and the pending W+1-bit result.
    int         m_rem = 0;
    logic [W:0] m_pend = '0;
    logic [W-1:0] m_diff = '0;
    logic       m_bout = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rem  <= 0;
            m_diff <= '0;
            m_bout <= 1'b0;
        end else if (m_rem == 0) begin
            if (bus.start) begin
                m_rem  <= W + 1;
                m_pend <= {1'b0, bus.a} - {1'b0, bus.b};
            end
        end else begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_diff <= m_pend[W-1:0];
                m_bout <= m_pend[W];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_rem != 0));
            check("done", 32'(bus.done), 32'(m_rem == 1));
            check("diff", 32'(bus.diff), 32'(m_diff));
            check("bout", 32'(bus.bout), 32'(m_bout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse, then wait (bounded) for done and check latency and result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] ed, input logic eb);
        int  n;
        bit  got;
        tick();
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        tick();
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            if (bus.done) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("done_seen", 32'(got), 32'(1));
        check("latency", 32'(n), 32'(W));
        check("op_diff", 32'(bus.diff), 32'(ed));
        check("op_bout", 32'(bus.bout), 32'(eb));
    endtask

    initial begin
        logic [W:0] r;
        int n;
        bit got;
        bus.start  = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        rst_n      = 1'b0;
        tick();
        tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_diff", 32'(bus.diff), 32'(0));
        check("rst_busy8", 32'(bus8.busy), 32'(0));
        check("rst_diff8", 32'(bus8.diff), 32'(0));

        run_op(4'b0101, 4'b0011, 4'b0010, 1'b0);
        run_op(4'b0011, 4'b0101, 4'b1110, 1'b1);
        run_op(4'b1000, 4'b0001, 4'b0111, 1'b0);
        run_op(4'b0000, 4'b1111, 4'b0001, 1'b1);
        run_op(4'b1111, 4'b1111, 4'b0000, 1'b0);

        // Start re-asserted during RUN must be ignored.
        tick();
        bus.start = 1'b1;
        bus.a     = 4'd7;
        bus.b     = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.a     = 4'b1111;
        bus.b     = 4'b0000;
        tick();
        bus.start = 1'b0;
        n   = 2;
        got = 1'b0;
        while (n < 20 && !got) begin
            if (bus.done) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("ign_done", 32'(got), 32'(1));
        check("ign_lat", 32'(n), 32'(W));
        check("ign_diff", 32'(bus.diff), 32'(4'd5));

        // Reset during the 2nd RUN cycle of 9-4 aborts with no done.
        tick();
        tick();
        bus.start = 1'b1;
        bus.a     = 4'd9;
        bus.b     = 4'd4;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_diff", 32'(bus.diff), 32'(0));
        check("abort_bout", 32'(bus.bout), 32'(0));
        run_op(4'd9, 4'd4, 4'b0101, 1'b0);

        for (int i = 0; i < 256; i++) begin
            r = {1'b0, 4'(i >> 4)} - {1'b0, 4'(i)};
            run_op(4'(i >> 4), 4'(i), r[W-1:0], r[W]);
        end

        // WIDTH=8 instance.
        tick();
        bus8.start = 1'b1;
        bus8.a     = 8'd200;
        bus8.b     = 8'd201;
        tick();
        bus8.start = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 30 && !got) begin
            if (bus8.done) got = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check("w8_done", 32'(got), 32'(1));
        check("w8_lat", 32'(n), 32'(8));
        check("w8_diff", 32'(bus8.diff), 32'(8'hFF));
        check("w8_bout", 32'(bus8.bout), 32'(1));

        // Random traffic, including held start and occasional reset.
        for (int i = 0; i < 600; i++) begin
            tick();
            bus.start = ($urandom_range(2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            rst_n     = ($urandom_range(59) != 0);
        end
        tick();
        rst_n     = 1'b1;
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
